// File: rtl/cpu_types_pkg.sv
// Shared types for the 5-stage pipeline.
// Holds hazard-unit state encoding and register index types.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    localparam regbits_t REG_ZERO = '0;

    typedef enum logic {
        RUN,
        HALTED
    } hazard_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the pipeline datapath and the hazard unit.
// The hazard modport is the controller's view of the bundle.
interface hazard_unit_if
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
);
    regbits_t           id_rs;
    regbits_t           id_rt;
    logic               id_uses_rt;
    logic               ex_memread;
    regbits_t           ex_rd;
    logic               ex_jump;
    logic               mem_branch_taken;
    logic               mem_req;
    logic               dhit;
    logic               ihit;
    logic               wb_halt;
    logic               pc_en;
    logic               ifid_en;
    logic               idex_en;
    logic               exmem_en;
    logic               memwb_en;
    logic               ifid_flush;
    logic               idex_flush;
    logic               exmem_flush;
    logic               memwb_flush;
    logic               halted;
    logic [CNT_W-1:0]   stall_count;
    logic [CNT_W-1:0]   flush_count;

    modport hazard (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rd,
        input  ex_jump, mem_branch_taken, mem_req, dhit, ihit,
        input  wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush, memwb_flush,
        output halted, stall_count, flush_count
    );

    modport datapath (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_rd,
        output ex_jump, mem_branch_taken, mem_req, dhit, ihit,
        output wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
        input  halted, stall_count, flush_count
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Synchronous clear, asynchronous active-high reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    // count up on inc, hold once saturated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline.
// Handles load-use, memory waits, taken branch/jump and halt.
module pipeline_hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_jump,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    hazard_state_t state_q;
    hazard_state_t state_d;
    logic          dmem_wait;
    logic          redirect;
    logic          load_use;
    logic          stall_inc;
    logic          flush_inc;

    assign dmem_wait = mem_req && !dhit;
    assign redirect  = mem_branch_taken || ex_jump;
    assign load_use  = ex_memread
                    && (ex_rd != REG_W'(REG_ZERO))
                    && ((ex_rd == id_rs)
                     || (id_uses_rt && (ex_rd == id_rt)));

    // state register: only reset leaves HALTED
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and latch controls, first matching hazard wins
    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        halted      = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (!RST) begin
            case (state_q)
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    if (wb_halt) begin
                        // entry cycle already looks halted
                        state_d = HALTED;
                        halted  = 1'b1;
                    end else if (dmem_wait) begin
                        // freeze front, drain a bubble into WB;
                        // any pending redirect stays in its latch
                        memwb_en    = 1'b1;
                        memwb_flush = 1'b1;
                    end else if (redirect) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = mem_branch_taken;
                        flush_inc   = 1'b1;
                    end else if (load_use) begin
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else if (!ihit) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                    stall_inc = !halted && !pc_en;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (stall_inc),
        .clear (1'b0),
        .count (stall_count)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (flush_inc),
        .clear (1'b0),
        .count (flush_count)
    );

endmodule
